// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial sequence detector with a registered match pulse and match counter.
// Optional build macro SEQ_DET_CNT_SAT_EN makes match_cnt saturate instead of wrap.
`default_nettype none

module seq_detector_prog #(
  parameter int               PAT_W       = 8,
  parameter int               LEN_W       = $clog2(PAT_W + 1),
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(3),
  parameter logic [LEN_W-1:0] DEF_LEN     = LEN_W'(3),
  parameter logic             DEF_OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [LEN_W-1:0] leff;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] cmp_mask;
  logic             hit;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    leff       = (len_q > PAT_W_L) ? PAT_W_L : len_q;
    hist_shift = {hist_q[PAT_W-2:0], x};
    fill_inc   = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_W'(1);
    cmp_mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      cmp_mask[i] = (LEN_W'(i) < leff);
    end
    // Only the newest leff bits take part in the comparison.
    hit = (leff != '0) && (fill_inc >= leff) &&
          (((hist_shift ^ pat_q) & cmp_mask) == '0);
`ifdef SEQ_DET_CNT_SAT_EN
    cnt_next = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
`else
    cnt_next = match_cnt_q + CNT_W'(1);
`endif
  end

  always_comb begin
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    out_d       = 1'b0;
    match_cnt_d = match_cnt_q;
    if (cfg_load) begin
      pat_d       = cfg_pattern;
      len_d       = cfg_len;
      ovl_d       = cfg_overlap;
      hist_d      = '0;
      fill_d      = '0;
      match_cnt_d = '0;
    end else if (x_valid) begin
      out_d = hit;
      if (hit) begin
        match_cnt_d = cnt_next;
      end
      if (hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= DEF_PATTERN;
      len_q       <= DEF_LEN;
      ovl_q       <= DEF_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      out_q       <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = match_cnt_q;

endmodule

`default_nettype wire
